// File: rtl/sync_ram.sv
// Synchronous single-port RAM with REQ/READY handshake, byte enables and a 1- or 2-cycle read pipeline.
// Define SYNC_RAM_CLEAR_ON_RESET_EN to zero-fill the whole array after every reset before READY rises.
module sync_ram #(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   REQ,
  input  logic                   WE,
  input  logic [DATA_SIZE/8-1:0] BE,
  input  logic [ADDR_SIZE-1:0]   ADDRESS,
  input  logic [DATA_SIZE-1:0]   DATA_IN,
  output logic                   READY,
  output logic [DATA_SIZE-1:0]   DATA_OUT,
  output logic                   VALID
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int NB    = DATA_SIZE / 8;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sync_ram: RD_LATENCY must be 1 or 2");
  end
  if (DATA_SIZE % 8 != 0) begin : g_bad_width
    $error("sync_ram: DATA_SIZE must be a multiple of 8");
  end

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   valid_q;
  logic [DATA_SIZE-1:0]   data_q;
  logic [DATA_SIZE-1:0]   mem_q [DEPTH];
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
  logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
`endif

  // WE=1 selects a read; requests only count once READY is already high.
  logic rd_acc, wr_acc;
  assign rd_acc = REQ && ready_q && WE;
  assign wr_acc = REQ && ready_q && !WE;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      CLEAR: begin
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
        cnt_d = cnt_q + ADDR_SIZE'(1);
        if (cnt_q == '1) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
`else
        state_d = RUN;
        ready_d = 1'b1;
`endif
      end
      RUN:     ready_d = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers sample together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= CLEAR;
      ready_q <= 1'b0;
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // NOTE: the array has no reset; clearing it, when wanted, is the sweep's job.
  always_ff @(posedge CLK) begin
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
    if (state_q == CLEAR) mem_q[cnt_q] <= '0;
`endif
    if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (BE[i]) mem_q[ADDRESS][8*i +: 8] <= DATA_IN[8*i +: 8];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                 p_valid_q;
    logic [DATA_SIZE-1:0] p_data_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        p_valid_q <= 1'b0;
        p_data_q  <= '0;
        valid_q   <= 1'b0;
        data_q    <= '0;
      end else begin
        p_valid_q <= rd_acc;
        if (rd_acc) p_data_q <= mem_q[ADDRESS];
        valid_q   <= p_valid_q;
        if (p_valid_q) data_q <= p_data_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= mem_q[ADDRESS];
      end
    end
  end

  assign READY    = ready_q;
  assign DATA_OUT = data_q;
  assign VALID    = valid_q;

endmodule

// File: tb/tb_sync_ram.sv
// Directed bench for sync_ram: one instance per legal read latency, driven by shared stimulus.
module tb_sync_ram;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ;
  logic        WE;
  logic [1:0]  BE;
  logic [7:0]  ADDRESS;
  logic [15:0] DATA_IN;

  logic        ready1, valid1, ready2, valid2;
  logic [15:0] data1, data2;

  int total = 0;
  int fails = 0;
  int n;

`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
  localparam int READY_EDGES = 256;
`else
  localparam int READY_EDGES = 1;
`endif

  always #5 CLK = ~CLK;

  sync_ram #(.DATA_SIZE(16), .ADDR_SIZE(8), .RD_LATENCY(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .BE(BE), .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN), .READY(ready1), .DATA_OUT(data1), .VALID(valid1)
  );

  sync_ram #(.DATA_SIZE(16), .ADDR_SIZE(8), .RD_LATENCY(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .BE(BE), .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN), .READY(ready2), .DATA_OUT(data2), .VALID(valid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic count_ready(output int edges);
    edges = 0;
    while (!(ready1 && ready2) && edges < 400) begin
      step();
      edges++;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    REQ = 1'b1; WE = 1'b0; ADDRESS = a; DATA_IN = d; BE = be;
    step();
    REQ = 1'b0;
    check("wr_no_valid1", valid1, 1'b0);
  endtask

  // Single read observed on both latencies: lat1 after one edge, lat2 after two.
  task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    REQ = 1'b1; WE = 1'b1; ADDRESS = a; BE = 2'b00;
    step();
    REQ = 1'b0;
    check({tag, "_v1"}, valid1, 1'b1);
    check({tag, "_d1"}, data1, exp);
    check({tag, "_v2_early"}, valid2, 1'b0);
    step();
    check({tag, "_v1_drop"}, valid1, 1'b0);
    check({tag, "_d1_hold"}, data1, exp);
    check({tag, "_v2"}, valid2, 1'b1);
    check({tag, "_d2"}, data2, exp);
  endtask

  initial begin
    RST_N = 1'b0; REQ = 1'b0; WE = 1'b1; BE = 2'b00; ADDRESS = '0; DATA_IN = '0;
    step();
    step();
    check("rst_ready1", ready1, 1'b0);
    check("rst_ready2", ready2, 1'b0);
    check("rst_valid1", valid1, 1'b0);
    check("rst_valid2", valid2, 1'b0);
    check("rst_data1", data1, 16'h0000);
    check("rst_data2", data2, 16'h0000);

    // A write held on REQ throughout CLEAR must be dropped.
    RST_N = 1'b1;
    REQ = 1'b1; WE = 1'b0; ADDRESS = 8'h05; DATA_IN = 16'hAAAA; BE = 2'b11;
    count_ready(n);
    REQ = 1'b0;
    check("ready_edges", n, READY_EDGES);

`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
    rd_check("zero_00", 8'h00, 16'h0000);
    rd_check("zero_7f", 8'h7F, 16'h0000);
    rd_check("zero_ff", 8'hFF, 16'h0000);
    rd_check("clear_wr_ignored", 8'h05, 16'h0000);
`endif

    wr(8'h10, 16'hBEEF, 2'b11);
    wr(8'h10, 16'h1234, 2'b10);
    rd_check("byte_merge", 8'h10, 16'h12EF);
    wr(8'h10, 16'hFFFF, 2'b00);
    rd_check("be_zero_noop", 8'h10, 16'h12EF);
    wr(8'h10, 16'h5634, 2'b01);
    rd_check("low_byte", 8'h10, 16'h1234);

    wr(8'h20, 16'h5A5A, 2'b11);
    rd_check("raw", 8'h20, 16'h5A5A);
    wr(8'hFF, 16'hC3C3, 2'b11);
    rd_check("addr_ff", 8'hFF, 16'hC3C3);

    // Streaming reads on consecutive edges.
    wr(8'h01, 16'h0001, 2'b11);
    wr(8'h02, 16'h0002, 2'b11);
    wr(8'h03, 16'h0003, 2'b11);
    REQ = 1'b1; WE = 1'b1; ADDRESS = 8'h01;
    step();
    ADDRESS = 8'h02;
    check("s0_v1", valid1, 1'b1);
    check("s0_d1", data1, 16'h0001);
    check("s0_v2", valid2, 1'b0);
    step();
    ADDRESS = 8'h03;
    check("s1_v1", valid1, 1'b1);
    check("s1_d1", data1, 16'h0002);
    check("s1_v2", valid2, 1'b1);
    check("s1_d2", data2, 16'h0001);
    step();
    REQ = 1'b0;
    check("s2_v1", valid1, 1'b1);
    check("s2_d1", data1, 16'h0003);
    check("s2_v2", valid2, 1'b1);
    check("s2_d2", data2, 16'h0002);
    step();
    check("s3_v1", valid1, 1'b0);
    check("s3_v2", valid2, 1'b1);
    check("s3_d2", data2, 16'h0003);
    step();
    check("s4_v2", valid2, 1'b0);
    check("s4_d2_hold", data2, 16'h0003);

    // Reset one cycle after a read is accepted: the lat2 read must vanish.
    REQ = 1'b1; WE = 1'b1; ADDRESS = 8'h10;
    step();
    REQ = 1'b0;
    RST_N = 1'b0;
    #1;
    check("flush_v2", valid2, 1'b0);
    check("flush_d2", data2, 16'h0000);
    check("flush_d1", data1, 16'h0000);
    check("flush_ready", ready1, 1'b0);
    step();
    step();
    check("flush_v2_later", valid2, 1'b0);
    RST_N = 1'b1;
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 64; i++) step();
    check("mid_sweep_ready", ready1, 1'b0);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
`endif
    count_ready(n);
    check("ready_edges_again", n, READY_EDGES);
    check("no_valid_after_rst", valid2, 1'b0);
`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
    rd_check("resweep_10", 8'h10, 16'h0000);
`else
    rd_check("kept_10", 8'h10, 16'h1234);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
# sync_ram

Synchronous, parametrised single-port RAM for the CPU datapath (instruction/data memory), replacing the level-sensitive combinational array. It adds a clock, a REQ/READY request handshake, per-byte write enables, a 1- or 2-cycle registered read pipeline with a VALID strobe, and an optional post-reset zero-fill sweep. One access (read or write) is accepted per cycle.

## Interface
- DATA_SIZE, 16, word width in bits; must be a multiple of 8.
- ADDR_SIZE, 8, address width; depth DEPTH = 2^ADDR_SIZE words.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2; any other value is an elaboration error.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  1  access request.
- WE  in  1  access type: WE=0 is a write, WE=1 is a read (codebase polarity).
- BE  in  DATA_SIZE/8  byte enables for writes; bit i covers DATA_IN[8i+7:8i].
- ADDRESS  in  ADDR_SIZE  word address.
- DATA_IN  in  DATA_SIZE  write data.
- READY  out  1  block accepts requests this cycle.
- DATA_OUT  out  DATA_SIZE  read data.
- VALID  out  1  one-cycle strobe; DATA_OUT holds read data.

## Operation
- States: CLEAR and RUN.
- RST_N low forces, asynchronously:
  - state = CLEAR, sweep counter = 0;
  - READY = 0, VALID = 0, DATA_OUT = 0;
  - read pipeline flushed.
- Memory contents are not reset by RST_N.
- CLEAR:
  - With the macro: each edge writes 0 to MEM[counter] and increments the counter. On the edge that writes DEPTH-1, the state goes to RUN and READY becomes 1.
  - Without the macro: the first edge after reset release goes straight to RUN.
- In CLEAR, READY = 0 and REQ is ignored; requests are neither queued nor buffered.
- RUN: READY = 1 permanently. An access is accepted on an edge where REQ=1 and READY=1.
- Accepted write:
  - MEM[ADDRESS] byte i is updated from DATA_IN only where BE[i]=1; other bytes are kept.
  - BE all zero is accepted as a no-op.
  - No VALID is generated.
- Accepted read: MEM[ADDRESS] is captured into the pipeline. DATA_OUT and VALID are produced RD_LATENCY edges later. BE is ignored.
- Back-to-back reads on consecutive cycles stream out in order, one per cycle.
- DATA_OUT holds its last read value when VALID=0.
- Read-after-write: a read accepted on the edge after the write's edge returns the new data. Being single-port, no same-cycle conflict exists.
- Address wrap: ADDRESS is exactly ADDR_SIZE wide, so no out-of-range access is possible.
- Reset mid-operation:
  - Reset during CLEAR restarts the sweep at address 0.
  - Reset with reads in flight drops them; no VALID follows.

## Timing
- Read accepted at edge N: VALID=1 and DATA_OUT valid after edge N+RD_LATENCY, held for exactly one cycle.
- Write accepted at edge N: new data visible to a read accepted at edge N+1.
- READY rise after reset release:
  - with the macro, after DEPTH edges (256 for defaults);
  - without it, after 1 edge.
- Throughput: 1 access per cycle in RUN. No combinational path from inputs to outputs.

## Configuration
- SYNC_RAM_CLEAR_ON_RESET_EN:
  - Defined: the CLEAR state performs the DEPTH-cycle zero-fill sweep described above, and reads of never-written locations return 0.
  - Undefined: no sweep and no sweep counter; CLEAR lasts one cycle, and unwritten locations read as undefined (X in simulation).

## Test plan
- Release reset with the macro defined and defaults: READY stays 0 for 256 edges, then goes 1; reads of addresses 0x00, 0x7F and 0xFF each return 0x0000 with VALID after 1 cycle.
- Write 0xBEEF to address 0x10 with BE=2'b11, then write 0x12xx to the same address with BE=2'b10 and DATA_IN=0x1234, then read: DATA_OUT=0x12EF.
- Set RD_LATENCY=2 and issue reads of addresses 1, 2, 3 on consecutive cycles after writing 0x0001, 0x0002, 0x0003: VALID is high for 3 consecutive cycles starting 2 cycles after the first read, with DATA_OUT=1, 2, 3 in order.
- Drive REQ=1 with a write during CLEAR: the write is ignored, and address 0x05 reads 0x0000 after the sweep.
- Assert RST_N low one cycle after a read is accepted (RD_LATENCY=2): VALID never rises and DATA_OUT=0; a second reset mid-sweep at counter 0x40 restarts READY timing at the full 256 edges.
- Write at edge N, then read the same address at edge N+1: the new data is returned with VALID at N+1+RD_LATENCY.
